// File: rtl/i2s_tx_serializer_fifo.sv
// FIFO-fed serial audio transmitter: Philips I2S, left/right-justified and TDM framing
// with 16/32-bit slots, mono duplication, and sticky overflow/underrun flags.
module i2s_tx_serializer_fifo #(
  parameter int SAMPLE_W = 32,
  parameter int DEPTH    = 8,
  parameter int NCH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       bit_en,
  input  logic                       wen,
  input  logic [SAMPLE_W-1:0]        din,
  input  logic [1:0]                 standard,
  input  logic                       frame_size,
  input  logic                       stereo,
  input  logic                       clr_flags,
  output logic                       dout,
  output logic                       ws,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic                       underrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [1:0] STD_PHILIPS = 2'b00;
  localparam logic [1:0] STD_RJ      = 2'b10;
  localparam logic [1:0] STD_TDM     = 2'b11;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t state_q, state_d;

  // FIFO storage and bookkeeping
  logic [SAMPLE_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]       count_q, count_d;
  logic                wr_acc, pop;

  // Serializer state; cfg registers hold the per-frame snapshot of the controls
  logic [4:0]          bit_q, bit_d;
  logic [2:0]          slot_q, slot_d;
  logic [1:0]          std_q, std_d;
  logic                s32_q, s32_d;
  logic                stereo_q, stereo_d;
  logic [SAMPLE_W-1:0] word_q, word_d;
  logic [31:0]         sr_q, sr_d;
  logic                dout_q, dout_d;
  logic                ws_q, ws_d;
  logic                ovf_q, ovf_d;
  logic                und_q, und_d;

  logic                frame_start;
  logic [1:0]          cur_std;
  logic                cur_s32, cur_stereo;
  logic                last_bit, last_slot, reuse;
  logic                advance, load, underrun_evt;
  logic [SAMPLE_W-1:0] load_word;
  logic [31:0]         img;
  logic                ws_val;

  // Place a word into a 32-bit slot image with slot bit 0 at image bit 31.
  function automatic logic [31:0] align_word(input logic [SAMPLE_W-1:0] w,
                                             input logic rj, input logic s32);
    logic [63:0] ext;
    logic [31:0] zext;
    ext = '0;
    ext[63 -: SAMPLE_W] = w;
    zext = '0;
    zext[SAMPLE_W-1:0] = w;
    align_word = ext[63:32];
    if (rj) begin
      if (s32) begin
        align_word = zext;
      end else if (SAMPLE_W <= 16) begin
        align_word = zext << 16;
      end
    end
  endfunction

  assign full   = (count_q == LW'(DEPTH));
  assign empty  = (count_q == '0);
  assign level  = count_q;
  assign wr_acc = wen && !full;

  // Controls are taken live at slot 0 bit 0 and frozen for the rest of the frame.
  assign frame_start = (bit_q == 5'd0) && (slot_q == 3'd0);
  assign cur_std     = frame_start ? standard   : std_q;
  assign cur_s32     = frame_start ? frame_size : s32_q;
  assign cur_stereo  = frame_start ? stereo     : stereo_q;

  assign last_bit  = cur_s32 ? (bit_q == 5'd31) : (bit_q == 5'd15);
  assign last_slot = (cur_std == STD_TDM) ? (slot_q == 3'(NCH - 1)) : (slot_q == 3'd1);
  assign reuse     = !cur_stereo && (cur_std != STD_TDM) && (slot_q == 3'd1);

  assign advance      = bit_en && ((state_q == ST_RUN) || !empty);
  assign load         = advance && (bit_q == 5'd0);
  assign pop          = load && !reuse && !empty;
  assign underrun_evt = load && !reuse && empty;

  assign load_word = reuse ? word_q : (empty ? '0 : mem_q[rd_ptr_q]);
  assign img       = align_word(load_word, cur_std == STD_RJ, cur_s32);

  // Philips leads the left/right level by one bit; TDM pulses on the frame's last bit.
  always_comb begin
    ws_val = 1'b0;
    case (cur_std)
      STD_PHILIPS: ws_val = (slot_q == 3'd0) ? last_bit : !last_bit;
      STD_TDM:     ws_val = last_slot && last_bit;
      default:     ws_val = (slot_q == 3'd1);
    endcase
  end

  assign count_d = count_q + LW'(wr_acc) - LW'(pop);

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    slot_d   = slot_q;
    std_d    = std_q;
    s32_d    = s32_q;
    stereo_d = stereo_q;
    word_d   = word_q;
    sr_d     = sr_q;
    dout_d   = dout_q;
    ws_d     = ws_q;
    if (advance) begin
      state_d = ST_RUN;
      if (frame_start) begin
        std_d    = standard;
        s32_d    = frame_size;
        stereo_d = stereo;
      end
      if (bit_q == 5'd0) begin
        dout_d = img[31];
        sr_d   = img << 1;
        if (slot_q == 3'd0) begin
          word_d = load_word;
        end
      end else begin
        dout_d = sr_q[31];
        sr_d   = sr_q << 1;
      end
      ws_d = ws_val;
      if (last_bit) begin
        bit_d  = 5'd0;
        slot_d = last_slot ? 3'd0 : slot_q + 3'd1;
      end else begin
        bit_d = bit_q + 5'd1;
      end
    end
  end

  assign ovf_d = (ovf_q && !clr_flags) || (wen && full);
  assign und_d = (und_q && !clr_flags) || underrun_evt;

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)    rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      bit_q    <= '0;
      slot_q   <= '0;
      std_q    <= '0;
      s32_q    <= 1'b0;
      stereo_q <= 1'b0;
      word_q   <= '0;
      sr_q     <= '0;
      dout_q   <= 1'b0;
      ws_q     <= 1'b0;
      ovf_q    <= 1'b0;
      und_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bit_q    <= bit_d;
      slot_q   <= slot_d;
      std_q    <= std_d;
      s32_q    <= s32_d;
      stereo_q <= stereo_d;
      word_q   <= word_d;
      sr_q     <= sr_d;
      dout_q   <= dout_d;
      ws_q     <= ws_d;
      ovf_q    <= ovf_d;
      und_q    <= und_d;
    end
  end

  assign dout     = dout_q;
  assign ws       = ws_q;
  assign overflow = ovf_q;
  assign underrun = und_q;

endmodule

// File: tb/tb_i2s_tx_serializer_fifo.sv
// Bench for i2s_tx_serializer_fifo: table-driven FIFO vectors, directed framing
// sequences and randomized traffic against a queue-based frame model.
module tb_i2s_tx_serializer_fifo;

  localparam int W     = 32;
  localparam int DEPTH = 8;
  localparam int NCH   = 4;

  logic         clk = 1'b0;
  logic         rst, bit_en, wen, frame_size, stereo, clr_flags;
  logic [W-1:0] din;
  logic [1:0]   standard;
  logic         dout, ws, full, empty, overflow, underrun;
  logic [3:0]   level;

  int checks   = 0;
  int failures = 0;

  i2s_tx_serializer_fifo #(.SAMPLE_W(W), .DEPTH(DEPTH), .NCH(NCH)) dut (
    .clk(clk), .rst(rst), .bit_en(bit_en), .wen(wen), .din(din),
    .standard(standard), .frame_size(frame_size), .stereo(stereo),
    .clr_flags(clr_flags), .dout(dout), .ws(ws), .full(full), .empty(empty),
    .level(level), .overflow(overflow), .underrun(underrun)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [W-1:0] exp_q[$];
  bit           m_run;
  int           m_k, m_s;
  logic [1:0]   m_std;
  logic         m_stereo, m_dout, m_ws, m_ovf, m_und;
  logic [W-1:0] m_word, m_w0;

  function automatic logic ref_bit(input logic [W-1:0] w, input int b, input int s,
                                   input logic [1:0] sd);
    int l, pad;
    if (sd != 2'b10) return (W - 1 - b >= 0) ? w[W-1-b] : 1'b0;
    l   = (W < s) ? W : s;
    pad = s - l;
    if (b < pad) return 1'b0;
    return w[W-l+s-1-b];
  endfunction

  function automatic logic ref_ws(input int slot, input int b, input int s,
                                  input logic [1:0] sd);
    if (sd == 2'b00) return (slot == 0) ? (b == s - 1) : (b != s - 1);
    if (sd == 2'b11) return (slot == NCH - 1) && (b == s - 1);
    return slot == 1;
  endfunction

  task automatic model_step();
    int size0, nsl, slot, b;
    logic ovf_evt, und_evt;
    if (rst) begin
      exp_q.delete();
      m_run = 0; m_k = 0; m_dout = 0; m_ws = 0; m_ovf = 0; m_und = 0;
      return;
    end
    size0   = exp_q.size();
    ovf_evt = wen && (size0 == DEPTH);
    und_evt = 1'b0;
    if (bit_en && (m_run || size0 > 0)) begin
      m_run = 1;
      if (m_k == 0) begin
        m_std = standard; m_s = frame_size ? 32 : 16; m_stereo = stereo;
      end
      nsl  = (m_std == 2'b11) ? NCH : 2;
      slot = m_k / m_s;
      b    = m_k % m_s;
      if (b == 0) begin
        if (slot == 1 && !m_stereo && m_std != 2'b11) m_word = m_w0;
        else if (size0 > 0) m_word = exp_q.pop_front();
        else begin m_word = '0; und_evt = 1'b1; end
        if (slot == 0) m_w0 = m_word;
      end
      m_dout = ref_bit(m_word, b, m_s, m_std);
      m_ws   = ref_ws(slot, b, m_s, m_std);
      m_k    = (m_k + 1) % (nsl * m_s);
    end
    if (wen && size0 < DEPTH) exp_q.push_back(din);
    m_ovf = (m_ovf && !clr_flags) || ovf_evt;
    m_und = (m_und && !clr_flags) || und_evt;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp_v, $time);
    end
  endtask

  task automatic check_all();
    chk("model_dout", dout, m_dout);
    chk("model_ws", ws, m_ws);
    chk("model_level", level, exp_q.size());
    chk("model_full", full, exp_q.size() == DEPTH);
    chk("model_empty", empty, exp_q.size() == 0);
    chk("model_overflow", overflow, m_ovf);
    chk("model_underrun", underrun, m_und);
  endtask

  // ---------------- driver tasks ----------------
  logic cap_d [128];
  logic cap_w [128];

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1; wen = 0; bit_en = 0; clr_flags = 0;
    cyc();
    rst = 0;
  endtask

  task automatic write_word(input logic [W-1:0] w);
    wen = 1; din = w; bit_en = 0;
    cyc();
    wen = 0;
  endtask

  task automatic run_bits(input int n);
    for (int i = 0; i < n; i++) begin
      bit_en = 1;
      cyc();
      cap_d[i] = dout;
      cap_w[i] = ws;
    end
    bit_en = 0;
  endtask

  task automatic set_cfg(input logic [1:0] sd, input logic fs, input logic st);
    standard = sd; frame_size = fs; stereo = st;
  endtask

  typedef struct {
    logic         wen;
    logic [W-1:0] din;
    logic         clr;
    logic [3:0]   exp_level;
    logic         exp_full;
    logic         exp_empty;
    logic         exp_ovf;
  } vec_t;

  vec_t        tbl [12];
  logic [63:0] pat64;
  logic [15:0] pat16;

  initial begin
    for (int i = 0; i < 8; i++)
      tbl[i] = '{1'b1, $urandom, 1'b0, 4'(i + 1), (i == 7), 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 32'hDEAD_BEEF, 1'b0, 4'd8, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 32'h0,         1'b1, 4'd8, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 32'h1234_5678, 1'b1, 4'd8, 1'b1, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 32'h0,         1'b1, 4'd8, 1'b1, 1'b0, 1'b0};

    rst = 1; bit_en = 0; wen = 0; din = '0; clr_flags = 0;
    set_cfg(2'b00, 1'b1, 1'b1);
    m_std = 0; m_s = 32; m_stereo = 1; m_word = '0; m_w0 = '0;

    // Reset state
    do_reset();
    chk("reset_level", level, 0);
    chk("reset_empty", empty, 1);
    chk("reset_full", full, 0);
    chk("reset_dout_ws", {dout, ws}, 0);
    chk("reset_flags", {overflow, underrun}, 0);

    // FIFO fill, overflow and flag-clear vectors
    foreach (tbl[i]) begin
      wen = tbl[i].wen; din = tbl[i].din; clr_flags = tbl[i].clr; bit_en = 0;
      cyc();
      chk("tbl_level", level, tbl[i].exp_level);
      chk("tbl_full", full, tbl[i].exp_full);
      chk("tbl_empty", empty, tbl[i].exp_empty);
      chk("tbl_overflow", overflow, tbl[i].exp_ovf);
    end
    clr_flags = 0;
    // Write while full with a pop in the same cycle is still dropped
    wen = 1; din = 32'h5555_AAAA; bit_en = 1;
    cyc();
    wen = 0; bit_en = 0;
    chk("full_pop_level", level, 7);
    chk("full_pop_overflow", overflow, 1);

    // Philips, 32-bit slots
    do_reset();
    set_cfg(2'b00, 1'b1, 1'b1);
    write_word(32'hFFFF_FFFF);
    write_word(32'h0000_0000);
    run_bits(64);
    for (int j = 0; j < 64; j++) begin
      chk("philips_dout", cap_d[j], j < 32);
      chk("philips_ws", cap_w[j], (j >= 31) && (j < 63));
    end

    // Right-justified, 32-bit slot, 16 significant bits
    do_reset();
    set_cfg(2'b10, 1'b1, 1'b1);
    write_word(32'h0000_8001);
    run_bits(32);
    for (int j = 0; j < 32; j++) chk("rj_dout", cap_d[j], (j == 16) || (j == 31));

    // TDM, four 16-bit slots
    do_reset();
    set_cfg(2'b11, 1'b0, 1'b1);
    write_word(32'hA5A5_0000);
    write_word(32'h0000_0000);
    write_word(32'hFFFF_0000);
    write_word(32'h1234_0000);
    run_bits(64);
    pat64 = 64'hA5A5_0000_FFFF_1234;
    for (int j = 0; j < 64; j++) begin
      chk("tdm_dout", cap_d[j], pat64[63-j]);
      chk("tdm_ws", cap_w[j], j == 63);
    end

    // Underrun on the second slot, then clear
    do_reset();
    set_cfg(2'b01, 1'b0, 1'b1);
    write_word(32'hC3C3_0000);
    run_bits(32);
    pat16 = 16'hC3C3;
    for (int j = 0; j < 32; j++) begin
      chk("und_dout", cap_d[j], (j < 16) ? pat16[15-j] : 1'b0);
      chk("und_ws", cap_w[j], j >= 16);
    end
    chk("und_flag", underrun, 1);
    clr_flags = 1;
    cyc();
    clr_flags = 0;
    chk("und_cleared", underrun, 0);

    // Reset mid-frame at slot 1 bit 5, with a write in the same cycle
    do_reset();
    set_cfg(2'b01, 1'b1, 1'b1);
    write_word(32'hAAAA_5555);
    write_word(32'h5555_AAAA);
    write_word(32'hF0F0_0F0F);
    write_word(32'h0F0F_F0F0);
    run_bits(37);
    rst = 1; bit_en = 1; wen = 1; din = 32'hFFFF_FFFF;
    cyc();
    rst = 0; bit_en = 0; wen = 0;
    chk("midrst_dout_ws", {dout, ws}, 0);
    chk("midrst_level", level, 0);
    run_bits(8);
    for (int j = 0; j < 8; j++) chk("midrst_idle_dout", cap_d[j], 0);
    write_word(32'h8000_0000);
    run_bits(2);
    chk("midrst_resume_msb", cap_d[0], 1);
    chk("midrst_resume_bit1", cap_d[1], 0);

    // Randomized traffic against the frame model
    for (int r = 0; r < 6; r++) begin
      int wen_pct;
      do_reset();
      set_cfg(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      wen_pct = $urandom_range(5, 40);
      for (int c = 0; c < 500; c++) begin
        bit_en    = ($urandom_range(0, 3) != 0);
        wen       = ($urandom_range(0, 99) < wen_pct);
        din       = $urandom;
        clr_flags = ($urandom_range(0, 31) == 0);
        rst       = ($urandom_range(0, 399) == 0);
        if ($urandom_range(0, 63) == 0)
          set_cfg(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        cyc();
      end
      rst = 0; bit_en = 0; wen = 0; clr_flags = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
